// File: rtl/fft_bitrev_reader.sv
// rtl/fft_bitrev_reader.sv - ping-pong reorder buffer turning bit-reversed FFT output into natural order
// Optional feature macro: FFT_BITREV_BYPASS_EN (adds per-frame natural-order bypass input).
module fft_bitrev_reader #(
    parameter int WIDTH = 17,
    parameter int LOG2N = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
`ifdef FFT_BITREV_BYPASS_EN
    input  logic             bypass,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_re,
    output logic [WIDTH-1:0] out_im,
    output logic [LOG2N-1:0] out_index,
    output logic             out_last
);
    localparam int N = 1 << LOG2N;
    localparam logic [LOG2N-1:0] LAST = {LOG2N{1'b1}};

    logic                 wr_bank_q, wr_bank_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [LOG2N-1:0]     wr_cnt_q, wr_cnt_d;
    logic [LOG2N-1:0]     rd_cnt_q, rd_cnt_d;
    logic [1:0]           full_q, full_d;
    logic [2*WIDTH-1:0]   mem_q [2][N];

    logic                 wr_fire, rd_fire;
    logic [LOG2N-1:0]     wr_addr;
    logic [2*WIDTH-1:0]   rd_word;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction

    assign in_ready = !full_q[wr_bank_q];
    assign wr_fire  = in_valid && in_ready;
    assign rd_fire  = out_valid && out_ready;

`ifdef FFT_BITREV_BYPASS_EN
    // The bypass choice is taken from the port on the first accept and held for the rest of the frame.
    logic byp_q, byp_eff;
    assign byp_eff = (wr_cnt_q == '0) ? bypass : byp_q;
    assign wr_addr = byp_eff ? wr_cnt_q : bitrev(wr_cnt_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_q <= 1'b0;
        end else if (wr_fire && wr_cnt_q == '0) begin
            byp_q <= bypass;
        end
    end
`else
    assign wr_addr = bitrev(wr_cnt_q);
`endif

    always_comb begin
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        full_d    = full_q;
        if (wr_fire) begin
            wr_cnt_d = wr_cnt_q + LOG2N'(1);
            if (wr_cnt_q == LAST) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end
        // Writer and reader never own the same bank, so the two full-bit updates cannot collide.
        if (rd_fire) begin
            rd_cnt_d = rd_cnt_q + LOG2N'(1);
            if (rd_cnt_q == LAST) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            full_q    <= '0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            full_q    <= full_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < N; i++) begin
                    mem_q[b][i] <= '0;
                end
            end
        end else if (wr_fire) begin
            mem_q[wr_bank_q][wr_addr] <= {in_re, in_im};
        end
    end

    assign rd_word   = mem_q[rd_bank_q][rd_cnt_q];
    assign out_valid = full_q[rd_bank_q];
    assign out_re    = out_valid ? rd_word[2*WIDTH-1:WIDTH] : '0;
    assign out_im    = out_valid ? rd_word[WIDTH-1:0] : '0;
    assign out_index = rd_cnt_q;
    assign out_last  = out_valid && (rd_cnt_q == LAST);
endmodule

// File: tb/tb_fft_bitrev_reader.sv
// tb/tb_fft_bitrev_reader.sv - scoreboard bench for the bit-reversal reorder buffer
module tb_fft_bitrev_reader;
    localparam int WIDTH = 17;
    localparam int LOG2N = 6;
    localparam int N     = 64;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic             in_ready, out_valid, out_last;
    logic [WIDTH-1:0] in_re = '0, in_im = '0, out_re, out_im;
    logic [LOG2N-1:0] out_index;
`ifdef FFT_BITREV_BYPASS_EN
    logic             bypass = 1'b0;
`endif

    fft_bitrev_reader #(.WIDTH(WIDTH), .LOG2N(LOG2N)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_re(in_re),
        .in_im(in_im),
`ifdef FFT_BITREV_BYPASS_EN
        .bypass(bypass),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_re(out_re),
        .out_im(out_im),
        .out_index(out_index),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;
        logic [LOG2N-1:0] idx;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             mon_e;
    int               n_checks = 0;
    int               n_fail = 0;
    int               cyc = 0;
    int               stalls = 0;
    bit               watch = 1'b0;
    bit               ov_before = 1'b0;
    logic [WIDTH-1:0] cap_re [N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [5:0] brev(input logic [5:0] a);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) r[5-i] = a[i];
        return r;
    endfunction

    // Monitor: every output transfer is checked against the head of the scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (watch && !in_ready) stalls++;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: index %0d re %0d with empty scoreboard", out_index, out_re);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_re", 64'(out_re), 64'(mon_e.re));
                chk("out_im", 64'(out_im), 64'(mon_e.im));
                chk("out_index", 64'(out_index), 64'(mon_e.idx));
                chk("out_last", 64'(out_last), 64'(mon_e.idx == 6'd63));
                cap_re[out_index] = out_re;
            end
        end
    end

    // byp_mode: 0 plain, 1 bypass=1 at start then toggling, 2 bypass=0 at start then toggling.
    task automatic write_frame(input logic [WIDTH-1:0] base, input int count, input int byp_mode);
        int guard;
        int src;
        exp_t e;
        logic [WIDTH-1:0] v;
        for (int k = 0; k < count; k++) begin
            in_valid = 1'b1;
            in_re    = base + 17'(k);
            in_im    = -(base + 17'(k));
`ifdef FFT_BITREV_BYPASS_EN
            if (byp_mode == 1)      bypass = (k == 0) ? 1'b1 : ~k[0];
            else if (byp_mode == 2) bypass = (k == 0) ? 1'b0 : k[0];
            else                    bypass = 1'b0;
`endif
            guard = 0;
            while (!in_ready && guard < 3000) begin
                @(negedge clk);
                guard++;
            end
            if (!in_ready) begin
                n_checks++;
                n_fail++;
                $display("FAIL write_timeout: sample %0d of frame base %0d never accepted", k, base);
                return;
            end
            if (k == count - 1) ov_before = out_valid;
            @(posedge clk);
            #1;
        end
        if (count == N) begin
            for (int j = 0; j < N; j++) begin
                src   = (byp_mode == 1) ? j : int'(brev(6'(j)));
                v     = base + 17'(src);
                e.re  = v;
                e.im  = -v;
                e.idx = 6'(j);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_remaining", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_re"}, 64'(out_re), 64'd0);
        chk({tag, "_out_im"}, 64'(out_im), 64'd0);
        chk({tag, "_out_index"}, 64'(out_index), 64'd0);
        chk({tag, "_out_last"}, 64'(out_last), 64'd0);
    endtask

    initial begin
        int g;
        int c0;

        // Reset state, then idle
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk_reset_outputs("idle");

        // Single frame, reorder and latency
        out_ready = 1'b1;
        write_frame(17'd0, N, 0);
        in_valid = 1'b0;
        chk("lat_before_last_accept", 64'(ov_before), 64'd0);
        chk("lat_valid_after", 64'(out_valid), 64'd1);
        chk("lat_index0", 64'(out_index), 64'd0);
        wait_drain();
        chk("frame_j1", 64'(cap_re[1]), 64'd32);
        chk("frame_j3", 64'(cap_re[3]), 64'd48);
        chk("frame_j32", 64'(cap_re[32]), 64'd1);
        chk("frame_j63", 64'(cap_re[63]), 64'd63);

        // Back-to-back streaming
        watch = 1'b1;
        c0 = cyc;
        write_frame(17'd100, N, 0);
        write_frame(17'd200, N, 0);
        write_frame(17'd300, N, 0);
        write_frame(17'd400, N, 0);
        in_valid = 1'b0;
        watch = 1'b0;
        chk("b2b_cycles", 64'(cyc - c0), 64'd256);
        chk("b2b_stalls", 64'(stalls), 64'd0);
        wait_drain();

        // Backpressure: both banks fill, third frame stalls
        out_ready = 1'b0;
        write_frame(17'd1000, N, 0);
        write_frame(17'd2000, N, 0);
        in_valid = 1'b0;
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_index", 64'(out_index), 64'd0);
            chk("bp_hold_re", 64'(out_re), 64'd1000);
        end
        @(posedge clk);
        #1;
        fork
            write_frame(17'd3000, N, 0);
            begin
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b1;
                g = 0;
                do begin
                    @(negedge clk);
                    g++;
                end while (!out_last && g < 200);
                chk("bp_last_seen", 64'(out_last), 64'd1);
                chk("bp_in_ready_at_last", 64'(in_ready), 64'd0);
                @(negedge clk);
                chk("bp_in_ready_after", 64'(in_ready), 64'd1);
            end
        join
        in_valid = 1'b0;
        wait_drain();

        // Reset with a partial write frame and a half-read frame
        out_ready = 1'b0;
        write_frame(17'd4000, N, 0);
        write_frame(17'd5000, 20, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (32) @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("mid_index32", 64'(out_index), 64'd32);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        write_frame(17'd6000, N, 0);
        in_valid = 1'b0;
        wait_drain();
        chk("post_rst_j1", 64'(cap_re[1]), 64'd6032);

`ifdef FFT_BITREV_BYPASS_EN
        // Bypass latched at frame start, then a bit-reversed frame
        write_frame(17'd7000, N, 1);
        in_valid = 1'b0;
        wait_drain();
        chk("byp_on_j1", 64'(cap_re[1]), 64'd7001);
        write_frame(17'd8000, N, 2);
        in_valid = 1'b0;
        wait_drain();
        chk("byp_off_j1", 64'(cap_re[1]), 64'd8032);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
